// File: rtl/latency_fifo.sv
// latency_fifo: credit-style FIFO whose may_push threshold leaves headroom for
// a producer that keeps pushing for MAY_PUSH_LATENCY (+ EXTRA_IN_FLIGHT)
// cycles after may_push drops. Pops return data READ_DATA_LATENCY cycles later.
module latency_fifo #(
  parameter int WIDTH             = 8,
  parameter int DEPTH             = 32,
  parameter int MAY_PUSH_LATENCY  = 5,
  parameter int EXTRA_IN_FLIGHT   = 0,
  parameter int READ_DATA_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     may_push,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     may_pop,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int THRESH = DEPTH - MAY_PUSH_LATENCY - EXTRA_IN_FLIGHT;
  localparam int RDL    = READ_DATA_LATENCY;

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_CNT = CW'(THRESH);

  // Reject parameter sets that cannot work.
  if (THRESH < 1) begin : g_bad_thresh
    $error("latency_fifo: DEPTH too small for MAY_PUSH_LATENCY + EXTRA_IN_FLIGHT");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("latency_fifo: DEPTH must be a power of two and >= 4");
  end
  if ((RDL < 1) || (RDL > 4)) begin : g_bad_rdl
    $error("latency_fifo: READ_DATA_LATENCY must be 1..4");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("latency_fifo: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;
  logic             push_ok,  pop_ok;

  logic [RDL-1:0]   vld_q;
  logic [WIDTH-1:0] dat_q [RDL];

  // Accept decisions and next-state for pointers, occupancy and sticky flags.
  always_comb begin
    push_ok  = push && !clear && (count_q != FULL_CNT);
    pop_ok   = pop  && !clear && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      // Pointers are AW bits wide, so +1 wraps DEPTH-1 -> 0 naturally.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && !push_ok) ovf_d = 1'b1;
      if (pop  && !pop_ok)  unf_d = 1'b1;
    end
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage write port.
  // NOTE: the storage array has no reset; it is never read before being
  // written because a pop requires a nonzero count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  // Read pipeline: each stage carries a valid bit; data stages only load when
  // the stage feeding them is valid, so the last stage holds the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RDL; i++) dat_q[i] <= '0;
    end else if (clear) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= pop_ok;
      if (pop_ok) dat_q[0] <= mem[rd_ptr_q];
      for (int i = 1; i < RDL; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign count     = count_q;
  assign may_push  = (count_q < THRESH_CNT);
  assign may_pop   = (count_q != '0);
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign pop_valid = vld_q[RDL-1];
  assign pop_data  = dat_q[RDL-1];

endmodule

// File: tb/tb_latency_fifo.sv
// Randomized self-checking bench for latency_fifo (WIDTH=8, DEPTH=16,
// MAY_PUSH_LATENCY=5, EXTRA_IN_FLIGHT=0, READ_DATA_LATENCY=2). The reference
// is a word queue plus a list of scheduled pop returns keyed by cycle number.
module tb_latency_fifo;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int MPL    = 5;
  localparam int EIF    = 0;
  localparam int RDL    = 2;
  localparam int THRESH = DEPTH - MPL - EIF;

  logic             clk = 1'b0;
  logic             rst;
  logic             may_push, may_pop, pop_valid, overflow, underflow;
  logic             push, pop, clear;
  logic [WIDTH-1:0] push_data, pop_data;
  logic [4:0]       count;

  latency_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MAY_PUSH_LATENCY(MPL),
    .EXTRA_IN_FLIGHT(EIF), .READ_DATA_LATENCY(RDL)
  ) dut (
    .clk(clk), .rst(rst), .may_push(may_push), .push(push),
    .push_data(push_data), .may_pop(may_pop), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .clear(clear),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              due;
    logic [WIDTH-1:0] d;
  } sched_t;

  logic [WIDTH-1:0] fifo_m [$];
  sched_t           sched_m [$];
  logic             ovf_m, unf_m;
  logic [WIDTH-1:0] last_m;
  int               cyc;
  int               n_vec = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_m.delete();
    sched_m.delete();
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    last_m = '0;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    logic exp_v;
    exp_v = (sched_m.size() > 0) && (sched_m[0].due == cyc);
    if (exp_v) begin
      last_m = sched_m[0].d;
      void'(sched_m.pop_front());
    end
    check("count",     32'(count),     32'(fifo_m.size()));
    check("may_push",  32'(may_push),  32'(fifo_m.size() < THRESH));
    check("may_pop",   32'(may_pop),   32'(fifo_m.size() != 0));
    check("pop_valid", 32'(pop_valid), 32'(exp_v));
    check("pop_data",  32'(pop_data),  32'(last_m));
    check("overflow",  32'(overflow),  32'(ovf_m));
    check("underflow", 32'(underflow), 32'(unf_m));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // One clock cycle: check outputs, apply inputs, advance the model.
  task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic q, input logic c);
    int     n;
    logic   pa, qa;
    sched_t s;
    check_outputs();
    push = p; push_data = d; pop = q; clear = c;
    if (c) begin
      fifo_m.delete();
      sched_m.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      n  = fifo_m.size();
      pa = p && (n < DEPTH);
      qa = q && (n > 0);
      if (p && !pa) ovf_m = 1'b1;
      if (q && !qa) unf_m = 1'b1;
      if (qa) begin
        s.due = cyc + RDL;
        s.d   = fifo_m.pop_front();
        sched_m.push_back(s);
      end
      if (pa) fifo_m.push_back(d);
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},    32'(count),     32'd0);
    check({tag, "_pvalid"},   32'(pop_valid), 32'd0);
    check({tag, "_pdata"},    32'(pop_data),  32'd0);
    check({tag, "_may_push"}, 32'(may_push),  32'd1);
    check({tag, "_may_pop"},  32'(may_pop),   32'd0);
    check({tag, "_ovf"},      32'(overflow),  32'd0);
    check({tag, "_unf"},      32'(underflow), 32'd0);
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = '0;
    model_reset();
    @(negedge clk);
    #1 check_reset_values("reset");
    tick();
    rst = 1'b0;
    idle(2);

    // Fill: may_push drops once count reaches THRESH, remaining pushes land.
    for (int i = 1; i <= 11; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check("thresh_may_push", 32'(may_push), 32'd0);
    check("thresh_count",    32'(count),    32'd11);
    for (int i = 12; i <= 16; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check("full_count", 32'(count),    32'd16);
    check("full_ovf",   32'(overflow), 32'd0);

    // Push while full is rejected; then drain in order.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd16);
    // Push+pop at full: pop accepted, push rejected.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("full_pp_count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle(4);

    // Underflow, then push+pop on empty.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("unf_set", 32'(underflow), 32'd1);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("empty_pp_count", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);
    check("aa_valid", 32'(pop_valid), 32'd1);
    check("aa_data",  32'(pop_data),  32'hAA);
    idle(3);

    // Steady push+pop at count=3 across several pointer wraps.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b1, 1'b0);
    check("steady_count", 32'(count), 32'd3);
    idle(4);

    // Fill to 8, launch pops, clear while they are in flight.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    check("clr_count", 32'(count),    32'd0);
    check("clr_ovf",   32'(overflow), 32'd0);
    idle(4);

    // Random traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 99) < 55), WIDTH'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset mid-stream with pops in flight.
    for (int i = 0; i < 6; i++) step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b1, 1'b0);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    idle(4);

    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 99) < 70), WIDTH'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < 30), 1'b0);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
